// File: rtl/intp_service_sequencer_if.sv
// Bundles the APB register bus, the interrupt-controller handshake and the
// CPU-side request/ack/done signals of the interrupt service sequencer.
interface intp_service_sequencer_if #(
  parameter int ID_WIDTH = 4
);
  // APB register access
  logic [1:0]          paddr_i;
  logic                pwrite_i;
  logic                penable_i;
  logic [7:0]          pwdata_i;
  logic [7:0]          prdata_o;
  logic                pready_o;
  logic                perror_o;

  // Interrupt controller side
  logic                intp_valid_i;
  logic [ID_WIDTH-1:0] intp_to_service_i;
  logic                intp_serviced_o;

  // CPU service agent side
  logic                cpu_irq_o;
  logic [ID_WIDTH-1:0] cpu_irq_id_o;
  logic                cpu_ack_i;
  logic                cpu_done_i;
  logic                busy_o;

  // Sequencer view
  modport slave (
    input  paddr_i, pwrite_i, penable_i, pwdata_i,
    output prdata_o, pready_o, perror_o,
    input  intp_valid_i, intp_to_service_i,
    output intp_serviced_o,
    output cpu_irq_o, cpu_irq_id_o,
    input  cpu_ack_i, cpu_done_i,
    output busy_o
  );

  // Controller / CPU / bus-master view
  modport master (
    output paddr_i, pwrite_i, penable_i, pwdata_i,
    input  prdata_o, pready_o, perror_o,
    output intp_valid_i, intp_to_service_i,
    input  intp_serviced_o,
    input  cpu_irq_o, cpu_irq_id_o,
    output cpu_ack_i, cpu_done_i,
    input  busy_o
  );
endinterface

// File: rtl/intp_service_sequencer.sv
// Interrupt service sequencer: accepts the controller's winning interrupt,
// raises it to the CPU, sequences ack/done under a programmable watchdog and
// returns a one-cycle serviced pulse. Small APB register file for control.
module intp_service_sequencer #(
  parameter int         NUM_OF_PERIPHERALS = 16,
  parameter int         ID_WIDTH           = $clog2(NUM_OF_PERIPHERALS),
  parameter logic [7:0] TIMEOUT_RESET      = 8'd100
) (
  input  logic                    pclk_i,
  input  logic                    prst_i,
  intp_service_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SERVICE = 3'd2,
    S_RELEASE = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_TOCNT   = 2'd3;

  state_t              state;
  state_t              state_nxt;

  logic                ctrl_enable;
  logic [7:0]          timeout_cfg;
  logic [ID_WIDTH-1:0] status_id;
  logic                status_to;
  logic [7:0]          tocnt;
  logic [7:0]          timer;
  logic [ID_WIDTH-1:0] irq_id;

  logic                apb_wr;
  logic                accept;
  logic                in_window;
  logic                done_hit;
  logic                timeout_hit;
  logic                busy;
  logic [7:0]          status_rd;
  logic [7:0]          rd_data;

  // Saturating 8-bit increment for the timeout counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign apb_wr = bus.penable_i & bus.pwrite_i;

  // Transaction events: accept, done, watchdog expiry (done beats timeout)
  always_comb begin
    accept      = (state == S_IDLE) && ctrl_enable && bus.intp_valid_i;
    in_window   = (state == S_REQ) || (state == S_SERVICE);
    done_hit    = in_window && bus.cpu_done_i;
    timeout_hit = in_window && !bus.cpu_done_i &&
                  (timeout_cfg != 8'd0) && (timer == timeout_cfg);
  end

  // State register
  always_ff @(posedge pclk_i) begin
    if (prst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; done in REQ counts as ack plus done
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_REQ;
      S_REQ: begin
        if (done_hit || timeout_hit) state_nxt = S_RELEASE;
        else if (bus.cpu_ack_i)      state_nxt = S_SERVICE;
      end
      S_SERVICE: if (done_hit || timeout_hit) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_HOLDOFF;
      S_HOLDOFF: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    busy                = (state != S_IDLE);
    bus.cpu_irq_o       = (state == S_REQ);
    bus.intp_serviced_o = (state == S_RELEASE);
    bus.busy_o          = busy;
    bus.cpu_irq_id_o    = irq_id;
  end

  // Watchdog timer: cleared on accept, free-runs through REQ and SERVICE
  always_ff @(posedge pclk_i) begin
    if (prst_i)         timer <= 8'd0;
    else if (accept)    timer <= 8'd0;
    else if (in_window) timer <= timer + 8'd1;
  end

  // Latched interrupt ID, held until the next accept
  always_ff @(posedge pclk_i) begin
    if (prst_i)      irq_id <= '0;
    else if (accept) irq_id <= bus.intp_to_service_i;
  end

  // Last-transaction status, captured on the way into RELEASE
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      status_id <= '0;
      status_to <= 1'b0;
    end else if (done_hit || timeout_hit) begin
      status_id <= irq_id;
      status_to <= timeout_hit;
    end
  end

  // Timeout counter: any write clears it, otherwise saturating count of expiries
  always_ff @(posedge pclk_i) begin
    if (prst_i)                                 tocnt <= 8'd0;
    else if (apb_wr && bus.paddr_i == ADDR_TOCNT) tocnt <= 8'd0;
    else if (timeout_hit)                       tocnt <= sat_inc8(tocnt);
  end

  // Writable configuration registers
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      ctrl_enable <= 1'b1;
      timeout_cfg <= TIMEOUT_RESET;
    end else if (apb_wr) begin
      if (bus.paddr_i == ADDR_CTRL)    ctrl_enable <= bus.pwdata_i[0];
      if (bus.paddr_i == ADDR_TIMEOUT) timeout_cfg <= bus.pwdata_i;
    end
  end

  // STATUS image: last ID, timed-out flag and live busy; other bits zero
  always_comb begin
    status_rd                = 8'd0;
    status_rd[ID_WIDTH-1:0]  = status_id;
    status_rd[4]             = status_to;
    status_rd[5]             = busy;
  end

  // Zero-wait-state APB response; read data only during a read access phase
  always_comb begin
    rd_data = 8'd0;
    case (bus.paddr_i)
      ADDR_CTRL:    rd_data[0] = ctrl_enable;
      ADDR_TIMEOUT: rd_data    = timeout_cfg;
      ADDR_STATUS:  rd_data    = status_rd;
      default:      rd_data    = tocnt;
    endcase
    bus.prdata_o = (bus.penable_i && !bus.pwrite_i) ? rd_data : 8'd0;
    bus.pready_o = bus.penable_i;
    bus.perror_o = apb_wr && (bus.paddr_i == ADDR_STATUS);
  end

endmodule

// File: tb/tb_intp_service_sequencer.sv
// Self-checking bench for intp_service_sequencer: directed and random
// transactions checked against a cycle-count reference model.
`timescale 1ns/1ps
module tb_intp_service_sequencer;

  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Reference model of the register-visible state
  bit         m_enable;
  int         m_timeout;
  int         m_status_id;
  bit         m_status_to;
  int         m_tocnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  intp_service_sequencer_if #(.ID_WIDTH(IDW)) bus ();

  intp_service_sequencer #(
    .NUM_OF_PERIPHERALS(16),
    .ID_WIDTH(IDW),
    .TIMEOUT_RESET(8'd100)
  ) dut (
    .pclk_i(clk),
    .prst_i(rst),
    .bus(bus)
  );

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_enable = 1'b1; m_timeout = 100; m_status_id = 0; m_status_to = 1'b0; m_tocnt = 0;
  endtask

  task automatic apb_write(input int addr, input int data);
    bus.paddr_i = 2'(addr); bus.pwrite_i = 1'b1; bus.pwdata_i = 8'(data); bus.penable_i = 1'b0;
    tick();
    bus.penable_i = 1'b1;
    #1;
    chk("pready_wr", 32'(bus.pready_o), 32'd1);
    chk("perror_wr", 32'(bus.perror_o), 32'(addr == 2));
    tick();
    bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    case (addr)
      0: m_enable = data[0];
      1: m_timeout = data & 255;
      3: m_tocnt = 0;
      default: ;
    endcase
  endtask

  task automatic apb_read(input int addr, output int data);
    bus.paddr_i = 2'(addr); bus.pwrite_i = 1'b0; bus.penable_i = 1'b0;
    tick();
    chk("prdata_setup_zero", 32'(bus.prdata_o), 32'd0);
    bus.penable_i = 1'b1;
    #1;
    data = int'(bus.prdata_o);
    chk("pready_rd", 32'(bus.pready_o), 32'd1);
    chk("perror_rd", 32'(bus.perror_o), 32'd0);
    tick();
    bus.penable_i = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    int v;
    apb_read(0, v); chk({tag, "_ctrl"}, 32'(v), 32'(m_enable));
    apb_read(1, v); chk({tag, "_timeout"}, 32'(v), 32'(m_timeout));
    apb_read(2, v); chk({tag, "_status"}, 32'(v), 32'(m_status_id + (m_status_to ? 16 : 0)));
    apb_read(3, v); chk({tag, "_tocnt"}, 32'(v), 32'(m_tocnt));
  endtask

  // One transaction: ack pulsed in cycle a, done pulsed in cycle d, counted
  // from the first cycle the request is visible to the CPU.
  task automatic run_txn(input int id, input int a, input int d);
    int  k, teff, end_c, r, last_irq;
    bit  to;
    bus.intp_valid_i = 1'b1;
    bus.intp_to_service_i = 4'(id);
    k = 0;
    tick();
    while (!bus.cpu_irq_o && k < 8) begin tick(); k++; end
    chk("accept_latency", 32'(k), 32'd0);
    chk("irq_rise", 32'(bus.cpu_irq_o), 32'd1);
    bus.intp_valid_i = 1'b0;
    bus.intp_to_service_i = 4'(id ^ 5);
    if (!bus.cpu_irq_o) return;
    teff     = (m_timeout == 0) ? (1 << 30) : m_timeout;
    end_c    = (d < teff) ? d : teff;
    to       = (m_timeout != 0) && (d > m_timeout);
    r        = end_c + 1;
    last_irq = (a < end_c) ? a : end_c;
    for (int c = 0; c <= r + 2; c++) begin
      chk("irq", 32'(bus.cpu_irq_o), 32'(c <= last_irq));
      chk("serviced", 32'(bus.intp_serviced_o), 32'(c == r));
      chk("busy", 32'(bus.busy_o), 32'(c <= r + 1));
      chk("irq_id_held", 32'(bus.cpu_irq_id_o), 32'(id));
      bus.cpu_ack_i  = (c == a);
      bus.cpu_done_i = (c == d);
      tick();
    end
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0;
    m_status_id = id;
    m_status_to = to;
    if (to && m_tocnt < 255) m_tocnt++;
  endtask

  initial begin
    int v, t0, rid, ra, rd;
    rst = 1'b1;
    bus.paddr_i = 2'd0; bus.pwrite_i = 1'b0; bus.penable_i = 1'b0; bus.pwdata_i = 8'd0;
    bus.intp_valid_i = 1'b0; bus.intp_to_service_i = 4'd0;
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_irq", 32'(bus.cpu_irq_o), 32'd0);
    chk("rst_serviced", 32'(bus.intp_serviced_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_irq_id", 32'(bus.cpu_irq_id_o), 32'd0);
    chk("rst_prdata", 32'(bus.prdata_o), 32'd0);
    chk("rst_pready", 32'(bus.pready_o), 32'd0);
    chk("rst_perror", 32'(bus.perror_o), 32'd0);
    rst = 1'b0;
    tick();
    check_regs("after_reset");

    // Basic handshake: ack 2 cycles after irq, done 3 cycles later
    run_txn(5, 2, 5);
    check_regs("basic");

    // STATUS is read-only; write flags an error and changes nothing
    apb_write(2, 8'hFF);
    check_regs("status_write");

    // ack/done while idle are ignored
    bus.cpu_ack_i = 1'b1; bus.cpu_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ack_busy", 32'(bus.busy_o), 32'd0);
      chk("idle_ack_serviced", 32'(bus.intp_serviced_o), 32'd0);
    end
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0;

    // Watchdog expiry, then saturation of the timeout counter
    apb_write(1, 10);
    run_txn(3, 0, 1000);
    check_regs("timeout_first");
    for (int i = 0; i < 299; i++) run_txn(3, 0, 1000);
    check_regs("timeout_saturated");
    apb_write(3, 8'h5A);
    check_regs("tocnt_cleared");

    // Done and timeout in the same cycle: done wins
    apb_write(1, 6);
    run_txn(4, 1, 6);
    check_regs("collision");

    // Watchdog disabled
    apb_write(1, 0);
    run_txn(9, 3, 500);
    check_regs("wd_disabled");

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      apb_write(1, int'($urandom_range(0, 15)));
      rid = int'($urandom_range(0, 15));
      ra  = int'($urandom_range(0, 12));
      rd  = int'($urandom_range(0, 20));
      run_txn(rid, ra, rd);
      check_regs("random");
    end

    // Enable cleared mid-service: transaction completes, no new accept
    apb_write(1, 0);
    bus.intp_valid_i = 1'b1; bus.intp_to_service_i = 4'd9;
    tick();
    chk("en_irq", 32'(bus.cpu_irq_o), 32'd1);
    bus.cpu_ack_i = 1'b1;
    tick();
    bus.cpu_ack_i = 1'b0;
    chk("en_service_irq", 32'(bus.cpu_irq_o), 32'd0);
    apb_write(0, 0);
    chk("en_still_busy", 32'(bus.busy_o), 32'd1);
    bus.cpu_done_i = 1'b1;
    tick();
    bus.cpu_done_i = 1'b0;
    chk("en_serviced", 32'(bus.intp_serviced_o), 32'd1);
    tick();
    chk("en_holdoff_serviced", 32'(bus.intp_serviced_o), 32'd0);
    chk("en_holdoff_busy", 32'(bus.busy_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("en_gated_busy", 32'(bus.busy_o), 32'd0);
      chk("en_gated_irq", 32'(bus.cpu_irq_o), 32'd0);
    end
    apb_write(0, 1);
    chk("en_commit_no_accept", 32'(bus.busy_o), 32'd0);
    tick();
    chk("en_reaccept_irq", 32'(bus.cpu_irq_o), 32'd1);
    chk("en_reaccept_id", 32'(bus.cpu_irq_id_o), 32'd9);
    bus.cpu_ack_i = 1'b1; bus.cpu_done_i = 1'b1;
    tick();
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0; bus.intp_valid_i = 1'b0;
    chk("en_reaccept_serviced", 32'(bus.intp_serviced_o), 32'd1);
    tick(); tick();
    m_status_id = 9; m_status_to = 1'b0;
    check_regs("enable_gating");

    // Back-to-back: IDs 7 then 2 with same-cycle ack+done
    bus.intp_valid_i = 1'b1; bus.intp_to_service_i = 4'd7;
    tick();
    t0 = cyc;
    chk("b2b_irq_7", 32'(bus.cpu_irq_o), 32'd1);
    chk("b2b_id_7", 32'(bus.cpu_irq_id_o), 32'd7);
    bus.cpu_ack_i = 1'b1; bus.cpu_done_i = 1'b1; bus.intp_to_service_i = 4'd2;
    tick();
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0;
    chk("b2b_serviced_7", 32'(bus.intp_serviced_o), 32'd1);
    chk("b2b_serviced_id_7", 32'(bus.cpu_irq_id_o), 32'd7);
    tick();
    chk("b2b_holdoff", 32'(bus.intp_serviced_o), 32'd0);
    tick();
    chk("b2b_idle", 32'(bus.busy_o), 32'd0);
    tick();
    chk("b2b_irq_2", 32'(bus.cpu_irq_o), 32'd1);
    chk("b2b_id_2", 32'(bus.cpu_irq_id_o), 32'd2);
    chk("b2b_spacing", 32'(cyc - t0), 32'd4);
    bus.cpu_ack_i = 1'b1; bus.cpu_done_i = 1'b1; bus.intp_valid_i = 1'b0;
    tick();
    bus.cpu_ack_i = 1'b0; bus.cpu_done_i = 1'b0;
    chk("b2b_serviced_2", 32'(bus.intp_serviced_o), 32'd1);
    chk("b2b_serviced_id_2", 32'(bus.cpu_irq_id_o), 32'd2);
    tick(); tick();
    m_status_id = 2; m_status_to = 1'b0;
    check_regs("back_to_back");

    // Reset during SERVICE abandons the transaction
    apb_write(1, 3);
    run_txn(6, 0, 100);
    apb_write(1, 50);
    bus.intp_valid_i = 1'b1; bus.intp_to_service_i = 4'd11;
    tick();
    bus.cpu_ack_i = 1'b1;
    tick();
    bus.cpu_ack_i = 1'b0; bus.intp_valid_i = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_irq", 32'(bus.cpu_irq_o), 32'd0);
    chk("mid_rst_serviced", 32'(bus.intp_serviced_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_irq_id", 32'(bus.cpu_irq_id_o), 32'd0);
    chk("mid_rst_prdata", 32'(bus.prdata_o), 32'd0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_serviced", 32'(bus.intp_serviced_o), 32'd0);
      chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
    end
    check_regs("after_mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
